// File: rtl/in_dispatcher_pkg.sv
// Shared constants, FSM encoding and helpers for the ingress packet dispatcher.
package in_dispatcher_pkg;

  localparam int unsigned NUM_CORES = 4;
  localparam int unsigned PTR_W     = 2;

  localparam logic [7:0] CTRL_BOP  = 8'hFF;
  localparam logic [7:0] CTRL_BODY = 8'h00;

  typedef enum logic [1:0] {StIdle, StReq, StStream} state_e;

  function automatic logic is_eop(input logic [7:0] ctrl);
    return (ctrl != CTRL_BODY) && (ctrl != CTRL_BOP);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/in_dispatch_fifo.sv
// Show-ahead synchronous FIFO with synchronous clear and almost-full flag.
module in_dispatch_fifo #(
  parameter int unsigned AW        = 5,
  parameter int unsigned AF_MARGIN = 4,
  parameter int unsigned W         = 72
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic [W-1:0] wdata,
  input  logic         rd,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         almost_full
);

  localparam int unsigned DEPTH   = 2 ** AW;
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);
  localparam logic [AW:0] AF_LVL   = (AW + 1)'(DEPTH - AF_MARGIN);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q;
  logic          full, do_wr, do_rd;

  assign empty       = (count_q == '0);
  assign full        = (count_q == FULL_LVL);
  assign almost_full = (count_q >= AF_LVL);
  assign do_rd       = rd && !empty;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign do_wr       = wr && (!full || do_rd);
  assign rdata       = mem[rptr_q];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_wr) wptr_q <= wptr_q + 1'b1;
      if (do_rd) rptr_q <= rptr_q + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/in_dispatcher.sv
// Splits the ingress packet stream into whole-packet transfers to cores, round-robin.
module in_dispatcher
  import in_dispatcher_pkg::*;
#(
  parameter int unsigned FIFO_AW     = 5,
  parameter int unsigned AF_MARGIN   = 4,
  parameter int unsigned ACK_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [63:0]          in_data,
  input  logic [7:0]           in_ctrl,
  input  logic                 in_wr,
  output logic                 in_rdy,
  input  logic [NUM_CORES-1:0] core_en,
  output logic [63:0]          out_data,
  output logic [NUM_CORES-1:0] out_wr,
  output logic [NUM_CORES-1:0] out_bop,
  output logic [NUM_CORES-1:0] out_eop,
  output logic [NUM_CORES-1:0] out_req,
  input  logic [NUM_CORES-1:0] out_ack,
  input  logic [NUM_CORES-1:0] out_rdy,
  output logic [15:0]          drop_cnt,
  output logic [15:0]          tmo_cnt
);

  localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

  state_e               state_q;
  logic [PTR_W-1:0]     ptr_q;
  logic [7:0]           tmo_q;
  logic                 first_q;
  logic                 discard_q;
  logic [71:0]          head;
  logic [7:0]           head_ctrl;
  logic [63:0]          head_data;
  logic                 fifo_empty, fifo_af, pop, trunc;
  logic [NUM_CORES-1:0] ptr_oh;

  in_dispatch_fifo #(
    .AW        (FIFO_AW),
    .AF_MARGIN (AF_MARGIN),
    .W         (72)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .wr          (in_wr),
    .wdata       ({in_ctrl, in_data}),
    .rd          (pop),
    .rdata       (head),
    .empty       (fifo_empty),
    .almost_full (fifo_af)
  );

  assign in_rdy    = !fifo_af;
  assign head_ctrl = head[71:64];
  assign head_data = head[63:0];
  assign ptr_oh    = {{(NUM_CORES - 1){1'b0}}, 1'b1} << ptr_q;
  // A bop showing up after the first word means the current packet lost its eop.
  assign trunc     = !fifo_empty && !first_q && (head_ctrl == CTRL_BOP);

  always_comb begin
    pop = 1'b0;
    case (state_q)
      StIdle:   pop = !fifo_empty && (core_en != '0) && (head_ctrl != CTRL_BOP);
      StStream: pop = !fifo_empty && out_rdy[ptr_q] && !trunc;
      default:  pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      tmo_q     <= '0;
      first_q   <= 1'b0;
      discard_q <= 1'b0;
      out_data  <= '0;
      out_wr    <= '0;
      out_bop   <= '0;
      out_eop   <= '0;
      out_req   <= '0;
      drop_cnt  <= '0;
      tmo_cnt   <= '0;
    end else begin
      out_wr  <= '0;
      out_bop <= '0;
      out_eop <= '0;
      case (state_q)
        StIdle: begin
          if ((core_en != '0) && !fifo_empty) begin
            if (head_ctrl != CTRL_BOP) begin
              // Count a run of orphan words as a single dropped packet.
              if (!discard_q) drop_cnt <= sat_inc(drop_cnt);
              discard_q <= 1'b1;
            end else begin
              discard_q <= 1'b0;
              if (core_en[ptr_q]) begin
                state_q <= StReq;
                out_req <= ptr_oh;
                tmo_q   <= '0;
              end else begin
                ptr_q <= ptr_q + 1'b1;
              end
            end
          end
        end
        StReq: begin
          if (!core_en[ptr_q]) begin
            out_req <= '0;
            ptr_q   <= ptr_q + 1'b1;
            state_q <= StIdle;
          end else if (out_ack[ptr_q]) begin
            state_q <= StStream;
            first_q <= 1'b1;
          end else if (tmo_q == TMO_LAST) begin
            out_req <= '0;
            tmo_cnt <= sat_inc(tmo_cnt);
            ptr_q   <= ptr_q + 1'b1;
            state_q <= StIdle;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        StStream: begin
          if (trunc) begin
            out_req  <= '0;
            drop_cnt <= sat_inc(drop_cnt);
            ptr_q    <= ptr_q + 1'b1;
            state_q  <= StIdle;
          end else if (pop) begin
            first_q  <= 1'b0;
            out_data <= head_data;
            out_wr   <= ptr_oh;
            if (head_ctrl == CTRL_BOP) out_bop <= ptr_oh;
            if (is_eop(head_ctrl)) begin
              out_eop <= ptr_oh;
              out_req <= '0;
              ptr_q   <= ptr_q + 1'b1;
              state_q <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_in_dispatcher.sv
// Self-checking bench for in_dispatcher against a packet-level reference model.
module tb_in_dispatcher;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] in_data;
  logic [7:0]  in_ctrl;
  logic        in_wr;
  logic        in_rdy;
  logic [3:0]  core_en, out_wr, out_bop, out_eop, out_req, out_ack, out_rdy;
  logic [63:0] out_data;
  logic [15:0] drop_cnt, tmo_cnt;

  always #5 clk = ~clk;

  in_dispatcher dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_ctrl  (in_ctrl),
    .in_wr    (in_wr),
    .in_rdy   (in_rdy),
    .core_en  (core_en),
    .out_data (out_data),
    .out_wr   (out_wr),
    .out_bop  (out_bop),
    .out_eop  (out_eop),
    .out_req  (out_req),
    .out_ack  (out_ack),
    .out_rdy  (out_rdy),
    .drop_cnt (drop_cnt),
    .tmo_cnt  (tmo_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Core-side behaviour: static levels or a randomised responder.
  logic [3:0] ack_static = 4'hF, ack_dyn = 4'h0, rdy_static = 4'hF, rdy_dyn = 4'hF;
  bit         ack_auto = 1'b0;
  int         rdy_mode = 0;  // 0 static, 1 random, 2 toggle core 0
  assign out_ack = ack_auto ? ack_dyn : ack_static;
  assign out_rdy = (rdy_mode == 0) ? rdy_static : rdy_dyn;

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (!out_req[k]) ack_dyn[k] = 1'b0;
      else if ($urandom_range(0, 3) == 0) ack_dyn[k] = 1'b1;
    end
    if (rdy_mode == 1) rdy_dyn = 4'($urandom);
    else if (rdy_mode == 2) rdy_dyn = {3'b111, ~rdy_dyn[0]};
    else rdy_dyn = 4'hF;
  end

  // Delivered word record: {core, bop, eop, data}
  typedef logic [67:0] rec_t;
  rec_t rx_q[$];
  rec_t exp_q[$];
  int   wr_cnt[4];
  int   req1_cycles;
  int   onehot_viol;

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      for (int k = 0; k < 4; k++) begin
        if (out_wr[k]) begin
          rx_q.push_back({2'(k), out_bop[k], out_eop[k], out_data});
          wr_cnt[k]++;
        end
      end
      if (out_req[1]) req1_cycles++;
      if ($countones(out_wr) > 1 || $countones(out_req) > 1 || $countones(out_bop) > 1 ||
          $countones(out_eop) > 1 || ((out_bop | out_eop) & ~out_wr) != 4'h0)
        onehot_viol++;
    end
  end

  // Packet-level reference model
  int         m_ptr, m_core, m_drop, m_tmo;
  bit         m_inpkt, m_orphan;
  logic [3:0] noack;

  function automatic void model_reset();
    m_ptr = 0; m_core = 0; m_drop = 0; m_tmo = 0;
    m_inpkt = 1'b0; m_orphan = 1'b0;
    rx_q.delete(); exp_q.delete();
    for (int k = 0; k < 4; k++) wr_cnt[k] = 0;
    req1_cycles = 0; onehot_viol = 0;
  endfunction

  function automatic void model_word(input logic [7:0] c, input logic [63:0] d);
    if (c == 8'hFF) begin
      if (m_inpkt) m_drop++;
      m_orphan = 1'b0;
      m_inpkt  = 1'b1;
      for (int i = 0; i < 16; i++) begin
        if (core_en[m_ptr] && !noack[m_ptr]) begin
          m_core = m_ptr;
          m_ptr  = (m_ptr + 1) % 4;
          break;
        end
        if (core_en[m_ptr]) m_tmo++;
        m_ptr = (m_ptr + 1) % 4;
      end
      exp_q.push_back({2'(m_core), 1'b1, 1'b0, d});
    end else if (!m_inpkt) begin
      if (!m_orphan) m_drop++;
      m_orphan = 1'b1;
    end else begin
      exp_q.push_back({2'(m_core), 1'b0, c != 8'h00, d});
      if (c != 8'h00) m_inpkt = 1'b0;
    end
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    in_wr = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic send_word(input logic [7:0] c, input logic [63:0] d);
    int n = 0;
    while (!in_rdy && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 1000) begin
      checks++;
      errors++;
      $display("FAIL in_rdy_wait: in_rdy=%b after %0d cycles, required 1", in_rdy, n);
    end
    in_wr = 1'b1; in_ctrl = c; in_data = d;
    @(posedge clk);
    #1;
    in_wr = 1'b0;
    model_word(c, d);
  endtask

  task automatic send_pkt(input int len, input logic [7:0] eop_ctrl);
    send_word(8'hFF, {$urandom, $urandom});
    for (int i = 0; i < len - 2; i++) send_word(8'h00, {$urandom, $urandom});
    send_word(eop_ctrl, {$urandom, $urandom});
  endtask

  task automatic wait_rx(input int budget);
    int n = 0;
    while (rx_q.size() < exp_q.size() && n < budget) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({out_data, out_wr, out_bop, out_eop, out_req, drop_cnt, tmo_cnt, in_rdy} !==
        {64'h0, 16'h0, 32'h0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: got wr=%b req=%b drop=%0d tmo=%0d rdy=%b data=%h, required all 0, rdy=1",
               out_wr, out_req, drop_cnt, tmo_cnt, in_rdy, out_data);
    end
  endtask

  task automatic test_basic();
    rec_t got, want;
    do_reset();
    core_en = 4'hF; noack = 4'h0; ack_auto = 1'b0; ack_static = 4'hF; rdy_mode = 0;
    for (int p = 0; p < 3; p++) send_pkt(4, 8'h01);
    wait_rx(500);
    checks++;
    if (wr_cnt[0] != 4 || wr_cnt[1] != 4 || wr_cnt[2] != 4 || wr_cnt[3] != 0) begin
      errors++;
      $display("FAIL basic_counts: got %0d/%0d/%0d/%0d words, required 4/4/4/0",
               wr_cnt[0], wr_cnt[1], wr_cnt[2], wr_cnt[3]);
    end
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL basic_len: got %0d words, required %0d", rx_q.size(), exp_q.size());
    end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      got = rx_q.pop_front(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL basic_word: got %h required %h", got, want);
      end
    end
  endtask

  task automatic test_enable();
    rec_t got, want;
    do_reset();
    core_en = 4'b1010; noack = 4'h0; ack_auto = 1'b0; ack_static = 4'hF; rdy_mode = 0;
    for (int p = 0; p < 4; p++) send_pkt($urandom_range(2, 6), 8'($urandom_range(1, 254)));
    wait_rx(500);
    checks++;
    if (wr_cnt[0] != 0 || wr_cnt[2] != 0) begin
      errors++;
      $display("FAIL enable_skip: got wr0=%0d wr2=%0d, required 0/0", wr_cnt[0], wr_cnt[2]);
    end
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL enable_len: got %0d words, required %0d", rx_q.size(), exp_q.size());
    end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      got = rx_q.pop_front(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL enable_word: got %h required %h", got, want);
      end
    end
  endtask

  task automatic test_timeout();
    rec_t got, want;
    do_reset();
    core_en = 4'hF; noack = 4'b0010; ack_auto = 1'b0; ack_static = 4'b1101; rdy_mode = 0;
    send_pkt(3, 8'h01);
    send_pkt(4, 8'h02);
    wait_rx(500);
    checks++;
    if (req1_cycles != 64) begin
      errors++;
      $display("FAIL tmo_req_len: got out_req[1] high %0d cycles, required 64", req1_cycles);
    end
    checks++;
    if (tmo_cnt !== 16'(m_tmo) || m_tmo != 1) begin
      errors++;
      $display("FAIL tmo_cnt: got %0d, required %0d", tmo_cnt, m_tmo);
    end
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL tmo_len: got %0d words, required %0d", rx_q.size(), exp_q.size());
    end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      got = rx_q.pop_front(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL tmo_word: got %h required %h", got, want);
      end
    end
  endtask

  task automatic test_orphans();
    rec_t got, want;
    logic [7:0] s1 [5] = '{8'h00, 8'h00, 8'hFF, 8'h00, 8'h01};
    logic [7:0] s2 [5] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'h01};
    do_reset();
    core_en = 4'hF; noack = 4'h0; ack_auto = 1'b0; ack_static = 4'hF; rdy_mode = 0;
    for (int i = 0; i < 5; i++) send_word(s1[i], {$urandom, $urandom});
    wait_rx(500);
    checks++;
    if (drop_cnt !== 16'(m_drop) || m_drop != 1) begin
      errors++;
      $display("FAIL orphan_drop: got %0d, required %0d", drop_cnt, m_drop);
    end
    for (int i = 0; i < 5; i++) send_word(s2[i], {$urandom, $urandom});
    wait_rx(500);
    checks++;
    if (drop_cnt !== 16'(m_drop) || m_drop != 2) begin
      errors++;
      $display("FAIL trunc_drop: got %0d, required %0d", drop_cnt, m_drop);
    end
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL orphan_len: got %0d words, required %0d", rx_q.size(), exp_q.size());
    end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      got = rx_q.pop_front(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL orphan_word: got %h required %h", got, want);
      end
    end
  endtask

  task automatic test_backpressure();
    rec_t got, want;
    do_reset();
    core_en = 4'hF; noack = 4'h0; ack_auto = 1'b0; ack_static = 4'hF; rdy_mode = 2;
    send_pkt(16, 8'h01);
    wait_rx(500);
    checks++;
    if (rx_q.size() != 16 || exp_q.size() != 16) begin
      errors++;
      $display("FAIL bp_len: got %0d words, required 16", rx_q.size());
    end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      got = rx_q.pop_front(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL bp_word: got %h required %h", got, want);
      end
    end
    // Park the FSM so nothing is popped while the FIFO fills.
    rdy_mode = 0;
    core_en = 4'h0;
    for (int i = 0; i < 28; i++) begin
      in_wr = 1'b1; in_ctrl = 8'h00; in_data = 64'(i);
      @(posedge clk);
      #1;
      if (i >= 26) begin
        checks++;
        if (in_rdy !== (i == 26)) begin
          errors++;
          $display("FAIL fill_rdy: after %0d writes got in_rdy=%b, required %b",
                   i + 1, in_rdy, i == 26);
        end
      end
    end
    in_wr = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    core_en = 4'hF; noack = 4'h0; ack_auto = 1'b0; ack_static = 4'hF; rdy_mode = 0;
    send_word(8'hFF, {$urandom, $urandom});
    send_word(8'h00, {$urandom, $urandom});
    send_word(8'h00, {$urandom, $urandom});
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (out_req !== 4'b0001) begin
      errors++;
      $display("FAIL mid_req: got out_req=%b before reset, required 0001", out_req);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({out_data, out_wr, out_bop, out_eop, out_req, drop_cnt, tmo_cnt} !== 112'h0) begin
      errors++;
      $display("FAIL mid_reset: got wr=%b bop=%b eop=%b req=%b data=%h, required all 0",
               out_wr, out_bop, out_eop, out_req, out_data);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    send_pkt(3, 8'h01);
    wait_rx(500);
    checks++;
    if (rx_q.size() != 3 || rx_q[0][67:66] !== 2'd0 || exp_q.size() != 3 ||
        rx_q[0] !== exp_q[0]) begin
      errors++;
      $display("FAIL post_reset_core: got %0d words first=%h, required 3 words first=%h",
               rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 68'h0,
               (exp_q.size() > 0) ? exp_q[0] : 68'h0);
    end
  endtask

  task automatic test_random();
    rec_t got, want;
    do_reset();
    core_en = 4'($urandom_range(1, 15));
    noack = 4'h0; ack_auto = 1'b1; rdy_mode = 1;
    for (int p = 0; p < 20; p++) begin
      send_pkt($urandom_range(2, 8), 8'($urandom_range(1, 254)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    wait_rx(5000);
    checks++;
    if (drop_cnt !== 16'h0 || tmo_cnt !== 16'h0 || onehot_viol != 0) begin
      errors++;
      $display("FAIL rand_stats: got drop=%0d tmo=%0d onehot_viol=%0d, required 0/0/0",
               drop_cnt, tmo_cnt, onehot_viol);
    end
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rand_len: got %0d words, required %0d", rx_q.size(), exp_q.size());
    end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      got = rx_q.pop_front(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL rand_word: got %h required %h", got, want);
      end
    end
  endtask

  initial begin
    reset = 1'b1; in_wr = 1'b0; in_ctrl = 8'h00; in_data = 64'h0;
    core_en = 4'hF; noack = 4'h0;
    test_reset();
    test_basic();
    test_enable();
    test_timeout();
    test_orphans();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
